// File: rtl/pad_skid_slice_pkg.sv
`default_nettype none
// ============================================================================
// Package   : pad_skid_pkg
// Purpose   : Shared types and the width-extension helper used by the
//             pad_skid_slice register slice.
// Contents  : ext_mode_e   - per-channel fill mode (zero / sign)
//             skid_state_e - per-channel occupancy view for assertions only
//             pad_extend() - fills bits above in_w with 0 or the data MSB
// Revision  : 1.0 - initial release
// ============================================================================
package pad_skid_pkg;

  // Widest extended word the helper supports; callers cast the result down.
  localparam int MAX_W = 64;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // The caller passes its IN_W localparam as in_w and casts the result to its
  // own OUT_W, so one function serves every width combination.
  function automatic logic [MAX_W-1:0] pad_extend(
    input logic [MAX_W-1:0] data,
    input int               in_w,
    input ext_mode_e        mode
  );
    logic             msb;
    logic [MAX_W-1:0] res;
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == in_w - 1) msb = data[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      res[i] = (i < in_w) ? data[i] : ((mode == EXT_SIGN) && msb);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pad_skid_slice_if.sv
`default_nettype none
// ============================================================================
// Interface : pad_skid_slice_if
// Purpose   : Groups the flat multi-channel handshake buses of pad_skid_slice.
// Signals   : in_valid/in_ready/in_data/in_sext  - producer side
//             out_valid/out_ready/out_data       - consumer side
//             out_par (PAD_SKID_SLICE_PARITY_EN) - per-channel word parity
// Modports  : master - environment (drives inputs, consumes outputs)
//             slave  - the slice itself
// Revision  : 1.0 - initial release
// ============================================================================
interface pad_skid_slice_if #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 2,
  parameter int PAD_W  = 1
);
  localparam int OUT_W = IN_W + PAD_W;

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*IN_W-1:0]  in_data;
  logic [NUM_CH-1:0]       in_sext;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*OUT_W-1:0] out_data;
`ifdef PAD_SKID_SLICE_PARITY_EN
  logic [NUM_CH-1:0]       out_par;

  modport master (output in_valid, in_data, in_sext, out_ready,
                  input  in_ready, out_valid, out_data, out_par);
  modport slave  (input  in_valid, in_data, in_sext, out_ready,
                  output in_ready, out_valid, out_data, out_par);
`else
  modport master (output in_valid, in_data, in_sext, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_sext, out_ready,
                  output in_ready, out_valid, out_data);
`endif

endinterface
`default_nettype wire

// File: rtl/pad_skid_slice_ch.sv
`default_nettype none
// ============================================================================
// Module    : pad_skid_ch
// Purpose   : Single-channel two-entry skid stage. Extends each accepted word
//             to OUT_W bits (zero or sign fill) and stores it already extended.
// Ports     : clk, rst_n           - clock, async active-low reset
//             i_valid/o_ready      - input handshake (o_ready = !skid valid)
//             i_data, i_sext       - input word and its fill mode
//             o_valid/i_ready      - output handshake
//             o_data               - extended word from the main register
//             o_par                - XOR of o_data (PAD_SKID_SLICE_PARITY_EN)
// Revision  : 1.0 - initial release
// ============================================================================
module pad_skid_ch
  import pad_skid_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int PAD_W = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_valid,
  output logic                  o_ready,
  input  wire logic [IN_W-1:0]  i_data,
  input  wire logic             i_sext,
  output logic                  o_valid,
  input  wire logic             i_ready,
`ifdef PAD_SKID_SLICE_PARITY_EN
  output logic                  o_par,
`endif
  output logic [IN_W+PAD_W-1:0] o_data
);
  localparam int OUT_W = IN_W + PAD_W;
`ifdef PAD_SKID_SLICE_PARITY_EN
  localparam int STORE_W = OUT_W + 1;  // parity rides in the top bit
`else
  localparam int STORE_W = OUT_W;
`endif

  logic [OUT_W-1:0]   w_ext;
  logic [STORE_W-1:0] w_word;
  logic               w_acc;
  logic               w_pop;

  logic               r_mvalid;
  logic               r_svalid;
  logic [STORE_W-1:0] r_mdata;
  logic [STORE_W-1:0] r_sdata;

  assign w_ext = OUT_W'(pad_extend(MAX_W'(i_data), IN_W, ext_mode_e'(i_sext)));
`ifdef PAD_SKID_SLICE_PARITY_EN
  assign w_word = {^w_ext, w_ext};
`else
  assign w_word = w_ext;
`endif

  assign w_acc = i_valid & ~r_svalid;
  assign w_pop = r_mvalid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mvalid <= 1'b0;
      r_svalid <= 1'b0;
      r_mdata  <= '0;
      r_sdata  <= '0;
    end else if (r_svalid) begin
      // FULL: no accept possible, only drain skid into main.
      if (w_pop) begin
        r_mdata  <= r_sdata;
        r_svalid <= 1'b0;
      end
    end else if (r_mvalid) begin
      if (w_acc && w_pop) begin
        r_mdata <= w_word;
      end else if (w_acc) begin
        r_sdata  <= w_word;
        r_svalid <= 1'b1;
      end else if (w_pop) begin
        r_mvalid <= 1'b0;
      end
    end else if (w_acc) begin
      r_mdata  <= w_word;
      r_mvalid <= 1'b1;
    end
  end

  assign o_ready = ~r_svalid;
  assign o_valid = r_mvalid;
  assign o_data  = r_mdata[OUT_W-1:0];
`ifdef PAD_SKID_SLICE_PARITY_EN
  assign o_par   = r_mdata[OUT_W];
`endif

  skid_state_e w_state;
  always_comb begin
    w_state = EMPTY;
    if (r_mvalid && r_svalid) w_state = FULL;
    else if (r_mvalid)        w_state = ONE;
  end

  a_skid_needs_main: assert property (@(posedge clk) disable iff (!rst_n)
                                      r_svalid |-> r_mvalid);
  a_no_accept_full:  assert property (@(posedge clk) disable iff (!rst_n)
                                      (w_state == FULL) |-> !w_acc);

endmodule
`default_nettype wire

// File: rtl/pad_skid_slice.sv
`default_nettype none
// ============================================================================
// Module    : pad_skid_slice
// Purpose   : NUM_CH independent width-extending register slices. Each channel
//             prepends PAD_W zero- or sign-fill bits to its IN_W-bit word and
//             adds one registered stage with a skid buffer (full throughput).
// Ports     : clk    - clock
//             rst_n  - asynchronous active-low reset
//             bus    - pad_skid_slice_if.slave (flat buses, channel 0 in LSBs)
// Macro     : PAD_SKID_SLICE_PARITY_EN adds bus.out_par, the per-channel XOR
//             of the extended word, timed identically to out_data.
// Revision  : 1.0 - initial release
// ============================================================================
module pad_skid_slice #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 2,
  parameter int PAD_W  = 1
) (
  input wire logic         clk,
  input wire logic         rst_n,
  pad_skid_slice_if.slave  bus
);
  localparam int OUT_W = IN_W + PAD_W;

  logic [NUM_CH-1:0]       w_in_ready;
  logic [NUM_CH-1:0]       w_out_valid;
  logic [NUM_CH*OUT_W-1:0] w_out_data;
`ifdef PAD_SKID_SLICE_PARITY_EN
  logic [NUM_CH-1:0]       w_out_par;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pad_skid_ch #(
      .IN_W  (IN_W),
      .PAD_W (PAD_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (bus.in_valid[g]),
      .o_ready (w_in_ready[g]),
      .i_data  (bus.in_data[g*IN_W +: IN_W]),
      .i_sext  (bus.in_sext[g]),
      .o_valid (w_out_valid[g]),
      .i_ready (bus.out_ready[g]),
`ifdef PAD_SKID_SLICE_PARITY_EN
      .o_par   (w_out_par[g]),
`endif
      .o_data  (w_out_data[g*OUT_W +: OUT_W])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
`ifdef PAD_SKID_SLICE_PARITY_EN
  assign bus.out_par   = w_out_par;
`endif

endmodule
`default_nettype wire
